// File: rtl/acq_echo_sequencer_pkg.sv
// rtl/acq_echo_sequencer_pkg.sv - shared state encoding and width defaults for the echo sequencer
package acq_echo_sequencer_pkg;

  localparam int DEF_DATABUS_WIDTH = 32;
  localparam int DEF_ECHO_WIDTH    = 16;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_PRE  = 5'b00010,
    S_WND  = 5'b00100,
    S_GAP  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

endpackage

// File: rtl/acq_echo_sequencer_param_check.sv
// rtl/acq_echo_sequencer_param_check.sv - combinational legality check of echo train timing parameters
module acq_param_check
  import acq_echo_sequencer_pkg::*;
#(
  parameter int DW = DEF_DATABUS_WIDTH,
  parameter int EW = DEF_ECHO_WIDTH
) (
  input  logic [DW-1:0] first_delay_i,
  input  logic [DW-1:0] echo_period_i,
  input  logic [DW-1:0] wnd_len_i,
  input  logic [EW-1:0] num_echoes_i,
  output logic          ok_o
);

  // wnd_len < echo_period guarantees a gap of at least one cycle between windows
  assign ok_o = (first_delay_i != '0) && (num_echoes_i != '0) &&
                (wnd_len_i != '0) && (wnd_len_i < echo_period_i);

endmodule

// File: rtl/acq_echo_sequencer.sv
// rtl/acq_echo_sequencer.sv - CPMG echo train sequencer driving the ADC acquisition window
module acq_echo_sequencer
  import acq_echo_sequencer_pkg::*;
#(
  parameter int DATABUS_WIDTH = DEF_DATABUS_WIDTH,
  parameter int ECHO_WIDTH    = DEF_ECHO_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [DATABUS_WIDTH-1:0] FIRST_DELAY,
  input  logic [DATABUS_WIDTH-1:0] ECHO_PERIOD,
  input  logic [DATABUS_WIDTH-1:0] WND_LEN,
  input  logic [ECHO_WIDTH-1:0]    NUM_ECHOES,
  input  logic                     ACQ_EN,
  output logic                     ACQ_WND,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [ECHO_WIDTH-1:0]    ECHO_IDX,
  output logic                     CFG_ERR,
  output logic                     OVERRUN
);

  localparam logic [DATABUS_WIDTH-1:0] ONE_D = DATABUS_WIDTH'(1);
  localparam logic [DATABUS_WIDTH-1:0] TWO_D = DATABUS_WIDTH'(2);
  localparam logic [ECHO_WIDTH-1:0]    ONE_E = ECHO_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [DATABUS_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATABUS_WIDTH-1:0] period_q, wlen_q;
  logic [ECHO_WIDTH-1:0]    nech_q, idx_q, idx_d;
  logic                     cfg_err_q, cfg_err_d, overrun_q, overrun_d;
  logic                     params_ok, start_req, accept, cnt_zero, last_echo, rise;

  acq_param_check #(.DW(DATABUS_WIDTH), .EW(ECHO_WIDTH)) u_param_check (
    .first_delay_i (FIRST_DELAY),
    .echo_period_i (ECHO_PERIOD),
    .wnd_len_i     (WND_LEN),
    .num_echoes_i  (NUM_ECHOES),
    .ok_o          (params_ok)
  );

  assign start_req = (state_q == S_IDLE) && START && !ABORT;
  assign accept    = start_req && params_ok;
  assign cnt_zero  = (cnt_q == '0);
  assign last_echo = (idx_q == nech_q - ONE_E);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      wlen_q    <= '0;
      nech_q    <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_err_d;
      overrun_q <= overrun_d;
      if (accept) begin
        period_q <= ECHO_PERIOD;
        wlen_q   <= WND_LEN;
        nech_q   <= NUM_ECHOES;
      end
    end
  end

  // The START edge itself counts as the first delay cycle, so PRE is skipped for a
  // delay of 1 and otherwise loaded with FIRST_DELAY-2 to land the rise on cycle t0+FIRST_DELAY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          if (FIRST_DELAY == ONE_D) begin
            state_d = S_WND;
            cnt_d   = WND_LEN - ONE_D;
          end else begin
            state_d = S_PRE;
            cnt_d   = FIRST_DELAY - TWO_D;
          end
        end
        S_PRE: if (cnt_zero) begin
          state_d = S_WND;
          cnt_d   = wlen_q - ONE_D;
        end else begin
          cnt_d = cnt_q - ONE_D;
        end
        S_WND: if (cnt_zero) begin
          if (last_echo) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
            cnt_d   = period_q - wlen_q - ONE_D;
          end
        end else begin
          cnt_d = cnt_q - ONE_D;
        end
        S_GAP: if (cnt_zero) begin
          state_d = S_WND;
          cnt_d   = wlen_q - ONE_D;
        end else begin
          cnt_d = cnt_q - ONE_D;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rise      = (state_d == S_WND) && (state_q != S_WND);
    idx_d     = idx_q;
    cfg_err_d = cfg_err_q;
    overrun_d = accept ? 1'b0 : overrun_q;
    if (accept) begin
      idx_d = '0;
    end else if (state_q == S_GAP && state_d == S_WND) begin
      idx_d = idx_q + ONE_E;
    end
    if (start_req) begin
      cfg_err_d = !params_ok;
    end
    if (rise && ACQ_EN) begin
      overrun_d = 1'b1;
    end
  end

  always_comb begin
    ACQ_WND  = (state_q == S_WND);
    BUSY     = (state_q != S_IDLE);
    DONE     = (state_q == S_DONE);
    ECHO_IDX = idx_q;
    CFG_ERR  = cfg_err_q;
    OVERRUN  = overrun_q;
  end

endmodule

// File: tb/tb_acq_echo_sequencer.sv
// tb/tb_acq_echo_sequencer.sv - scoreboard bench for the echo train sequencer
module tb_acq_echo_sequencer;

  localparam int DW = 32;
  localparam int EW = 16;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [DW-1:0] FIRST_DELAY = '0;
  logic [DW-1:0] ECHO_PERIOD = '0;
  logic [DW-1:0] WND_LEN = '0;
  logic [EW-1:0] NUM_ECHOES = '0;
  logic          ACQ_EN = 1'b0;
  logic          ACQ_WND, BUSY, DONE, CFG_ERR, OVERRUN;
  logic [EW-1:0] ECHO_IDX;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  t0;
  logic prev_wnd = 1'b0;
  ev_t exp_q[$];

  acq_echo_sequencer #(.DATABUS_WIDTH(DW), .ECHO_WIDTH(EW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .ABORT       (ABORT),
    .FIRST_DELAY (FIRST_DELAY),
    .ECHO_PERIOD (ECHO_PERIOD),
    .WND_LEN     (WND_LEN),
    .NUM_ECHOES  (NUM_ECHOES),
    .ACQ_EN      (ACQ_EN),
    .ACQ_WND     (ACQ_WND),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ECHO_IDX    (ECHO_IDX),
    .CFG_ERR     (CFG_ERR),
    .OVERRUN     (OVERRUN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic push_train(input int t, input int fd, input int ep, input int wl, input int n);
    for (int k = 0; k < n; k++) begin
      push_ev(EV_RISE, t + fd + k * ep, k);
      push_ev(EV_FALL, t + fd + k * ep + wl, k);
    end
    push_ev(EV_DONE, t + fd + (n - 1) * ep + wl, n - 1);
  endtask

  task automatic got(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d idx=%0d", kind, cyc, ECHO_IDX);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.idx != int'(ECHO_IDX)) begin
        errors++;
        $display("FAIL event: got kind=%0d cycle=%0d idx=%0d expected kind=%0d cycle=%0d idx=%0d",
                 kind, cyc, ECHO_IDX, e.kind, e.cyc, e.idx);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (prev_wnd && !ACQ_WND) got(EV_FALL);
      if (!prev_wnd && ACQ_WND) got(EV_RISE);
      if (DONE) got(EV_DONE);
    end
    prev_wnd = ACQ_WND;
  end

  task automatic start_train(input int fd, input int ep, input int wl, input int n);
    FIRST_DELAY = DW'(fd);
    ECHO_PERIOD = DW'(ep);
    WND_LEN     = DW'(wl);
    NUM_ECHOES  = EW'(n);
    START       = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("scoreboard_drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_acq_wnd", ACQ_WND, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_echo_idx", ECHO_IDX, 0);
    chk("reset_cfg_err", CFG_ERR, 0);
    chk("reset_overrun", OVERRUN, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // case 1: nominal three-echo train
    t0 = cyc;
    push_train(t0, 3, 10, 4, 3);
    start_train(3, 10, 4, 3);
    chk("c1_busy_first", BUSY, 1);
    wait_until(t0 + 27);
    chk("c1_busy_done_cycle", BUSY, 1);
    chk("c1_done_pulse", DONE, 1);
    wait_until(t0 + 28);
    chk("c1_busy_after", BUSY, 0);
    chk("c1_done_after", DONE, 0);
    chk("c1_echo_idx_hold", ECHO_IDX, 2);
    drain();

    // case 2: window as long as period is rejected
    t0 = cyc;
    start_train(1, 10, 10, 2);
    chk("c2_cfg_err", CFG_ERR, 1);
    chk("c2_busy", BUSY, 0);
    wait_until(t0 + 30);
    chk("c2_cfg_err_sticky", CFG_ERR, 1);

    // case 3: minimum single-echo train, also clears CFG_ERR
    t0 = cyc;
    push_train(t0, 1, 2, 1, 1);
    start_train(1, 2, 1, 1);
    chk("c3_cfg_err_cleared", CFG_ERR, 0);
    wait_until(t0 + 3);
    chk("c3_busy_after", BUSY, 0);
    chk("c3_echo_idx", ECHO_IDX, 0);
    drain();

    // case 4: ACQ_EN still high when the second window rises
    t0 = cyc;
    push_train(t0, 3, 10, 4, 3);
    start_train(3, 10, 4, 3);
    wait_until(t0 + 5);
    chk("c4_overrun_clear", OVERRUN, 0);
    wait_until(t0 + 11);
    ACQ_EN = 1'b1;
    wait_until(t0 + 15);
    ACQ_EN = 1'b0;
    chk("c4_overrun_set", OVERRUN, 1);
    wait_until(t0 + 28);
    chk("c4_overrun_sticky", OVERRUN, 1);
    chk("c4_busy_after", BUSY, 0);
    drain();

    // case 5: abort inside the second window
    t0 = cyc;
    push_ev(EV_RISE, t0 + 3, 0);
    push_ev(EV_FALL, t0 + 7, 0);
    push_ev(EV_RISE, t0 + 13, 1);
    push_ev(EV_FALL, t0 + 15, 1);
    start_train(3, 10, 4, 3);
    chk("c5_overrun_cleared", OVERRUN, 0);
    wait_until(t0 + 14);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("c5_busy_abort", BUSY, 0);
    chk("c5_wnd_abort", ACQ_WND, 0);
    wait_until(t0 + 35);
    chk("c5_echo_idx_hold", ECHO_IDX, 1);
    drain();
    t0 = cyc;
    push_train(t0, 3, 10, 4, 3);
    start_train(3, 10, 4, 3);
    wait_until(t0 + 29);
    drain();

    // case 6: START while busy is ignored, then asynchronous reset in the second gap
    t0 = cyc;
    push_ev(EV_RISE, t0 + 3, 0);
    push_ev(EV_FALL, t0 + 7, 0);
    push_ev(EV_RISE, t0 + 13, 1);
    push_ev(EV_FALL, t0 + 17, 1);
    start_train(3, 10, 4, 3);
    wait_until(t0 + 2);
    ACQ_EN = 1'b1;
    @(negedge CLK);
    ACQ_EN = 1'b0;
    chk("c6_overrun_set", OVERRUN, 1);
    wait_until(t0 + 15);
    start_train(1, 2, 1, 1);
    chk("c6_busy_ignore_start", BUSY, 1);
    chk("c6_cfg_err_ignore_start", CFG_ERR, 0);
    wait_until(t0 + 19);
    chk("c6_echo_idx_pre_reset", ECHO_IDX, 1);
    RESET = 1'b1;
    #1;
    chk("c6_async_busy", BUSY, 0);
    chk("c6_async_echo_idx", ECHO_IDX, 0);
    chk("c6_async_overrun", OVERRUN, 0);
    chk("c6_async_acq_wnd", ACQ_WND, 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    drain();

    // recovery after reset
    t0 = cyc;
    push_train(t0, 1, 2, 1, 1);
    start_train(1, 2, 1, 1);
    wait_until(t0 + 4);
    chk("c6_recover_busy", BUSY, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
